ps2_scancode_receiver: RTL and testbench

//  Upstream stage of the keyboard-driven game datapath. Samples raw PS/2 clock/data from the keyboard,

---
 rtl/ps2_scancode_receiver.sv | 234 +++++++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
//   Receives PS/2 keyboard frames and presents one make code at a time to the game detector.
//   The raw PS/2 clock and data lines are synchronized, and the clock line is glitch-filtered.
//   The block deframes 11-bit frames (start, 8 data bits LSB first, odd parity, stop).
//   E0 prefixes are dropped. An F0 break prefix and the code that follows it are both dropped.
//   Every other code is latched on oData and announced with oKeyboardFlag.
//   The consumer reads oData on the falling edge of oKeyboardFlag.
//
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, a frame with a parity mismatch is dropped and pulses
//                        oFrameError; when undefined the parity bit is captured but ignored.
//
// Ports:
//   Clock           system clock, all logic on posedge
//   Reset           asynchronous, active-high reset
//   iPS2Clock       raw PS/2 clock (asynchronous, idle high)
//   iPS2Data        raw PS/2 data (asynchronous, idle high)
//   iKeyboardReset  downstream request to drop the strobe early (level, sampled on Clock)
//   oData           last accepted make code, bit 0 = first data bit on the wire
//   oKeyboardFlag   high while a new code is pending; falling edge marks oData valid
//   oFrameError     one-cycle pulse on start/stop/parity error or mid-frame timeout
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FLAG_HOLD      = 1000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2Clock,
  input  logic       iPS2Data,
  input  logic       iKeyboardReset,
  output logic [7:0] oData,
  output logic       oKeyboardFlag,
  output logic       oFrameError
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TimeW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned HoldW = (FLAG_HOLD > 1) ? $clog2(FLAG_HOLD) : 1;

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBreak = 8'hF0;

  // ---------------------------------------------------------------------------------------------
  // Input synchronizers (reset to the idle-high line level)
  // ---------------------------------------------------------------------------------------------
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= iPS2Clock;
      clk_s2 <= clk_s1;
      dat_s1 <= iPS2Data;
      dat_s2 <= dat_s1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Clock filter: the level flips once FILTER_LEN consecutive samples disagree with it.
  // The fall is flagged in the same cycle the filter accepts the new low level.
  // ---------------------------------------------------------------------------------------------
  logic             filt_level_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             filt_flip;
  logic             ps2_fall;

  always_comb begin
    filt_flip = (clk_s2 != filt_level_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
    ps2_fall  = filt_flip && filt_level_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      filt_level_q <= 1'b1;
      filt_cnt_q   <= '0;
    end else if (clk_s2 == filt_level_q) begin
      filt_cnt_q <= '0;
    end else if (filt_flip) begin
      filt_level_q <= clk_s2;
      filt_cnt_q   <= '0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             parity_q;
  logic [TimeW-1:0] tmo_cnt_q;
  logic             code_valid_q;
  logic [7:0]       code_q;
  logic             frame_err_q;
  logic             frame_ok;

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = dat_s2 && (^{shreg_q, parity_q});
`else
    frame_ok = dat_s2;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (ps2_fall) begin
        tmo_cnt_q <= '0;
        unique case (state_q)
          StIdle: begin
            if (!dat_s2) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          StData: begin
            shreg_q[bit_cnt_q] <= dat_s2;
            bit_cnt_q          <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= dat_s2;
            state_q  <= StStop;
          end
          StStop: begin
            if (frame_ok) begin
              code_valid_q <= 1'b1;
              code_q       <= shreg_q;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q != StIdle) begin
        // PS/2 clock stalled mid-frame: abandon the partial frame
        if (tmo_cnt_q == TimeW'(TIMEOUT_CYCLES - 1)) begin
          state_q     <= StIdle;
          tmo_cnt_q   <= '0;
          frame_err_q <= 1'b1;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Code filtering and strobe generation
  // ---------------------------------------------------------------------------------------------
  logic             break_q;
  logic             pend_q;
  logic [7:0]       pend_code_q;
  logic [7:0]       data_q;
  logic             flag_q;
  logic [HoldW-1:0] hold_q;
  logic             accept;

  always_comb begin
    accept = code_valid_q && (code_q != CodeExt) && (code_q != CodeBreak) && !break_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      break_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      data_q      <= '0;
      flag_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      pend_q <= 1'b0;

      if (code_valid_q) begin
        if (code_q == CodeBreak) begin
          break_q <= 1'b1;
        end else if (code_q != CodeExt) begin
          break_q <= 1'b0;
        end
      end

      if (pend_q) begin
        data_q <= pend_code_q;
        flag_q <= 1'b1;
        hold_q <= '0;
      end else if (accept) begin
        if (flag_q) begin
          // Force one low cycle so the consumer sees a falling edge for the old code
          flag_q      <= 1'b0;
          pend_q      <= 1'b1;
          pend_code_q <= code_q;
        end else begin
          data_q <= code_q;
          flag_q <= 1'b1;
          hold_q <= '0;
        end
      end else if (flag_q) begin
        if (iKeyboardReset || (hold_q == HoldW'(FLAG_HOLD - 1))) begin
          flag_q <= 1'b0;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end

  assign oData         = data_q;
  assign oKeyboardFlag = flag_q;
  assign oFrameError   = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver
//   Directed scenarios followed by a randomized stream of frames.
//   Expected codes and error pulses come from a byte-level model of the prefix rules.
module tb_ps2_scancode_receiver;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 200;
  localparam int unsigned FH = 300;
  localparam int unsigned H  = 8;   // PS/2 half period in system clocks

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParChk = 1'b1;
`else
  localparam bit ParChk = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iPS2Clock;
  logic       iPS2Data;
  logic       iKeyboardReset;
  logic [7:0] oData;
  logic       oKeyboardFlag;
  logic       oFrameError;

  ps2_scancode_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .FLAG_HOLD     (FH)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iPS2Clock     (iPS2Clock),
    .iPS2Data      (iPS2Data),
    .iKeyboardReset(iKeyboardReset),
    .oData         (oData),
    .oKeyboardFlag (oKeyboardFlag),
    .oFrameError   (oFrameError)
  );

  always #5 Clock = ~Clock;

  int unsigned cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Byte-level reference model
  logic [7:0] exp_q[$];
  bit         brk = 1'b0;
  logic [7:0] last_code = 8'h00;
  int         exp_err = 0;
  int         err_seen = 0;

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
    end else if (b == 8'hF0) begin
      brk = 1'b1;
    end else if (brk) begin
      brk = 1'b0;
    end else begin
      exp_q.push_back(b);
      last_code = b;
    end
  endfunction

  // Monitor: every flag fall consumes one expected code
  logic        flag_prev = 1'b0;
  logic [7:0]  data_prev = 8'h00;
  int unsigned rise_cyc = 0;
  int unsigned fall_cyc = 0;
  int unsigned stop_cyc = 0;

  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        flag_prev = 1'b0;
      end else begin
        if (oFrameError) err_seen++;
        if (oKeyboardFlag && !flag_prev) rise_cyc = cyc;
        if (oKeyboardFlag && flag_prev && (oData !== data_prev))
          check_eq("data_stable", 32'(oData), 32'(data_prev));
        if (!oKeyboardFlag && flag_prev) begin
          fall_cyc = cyc;
          if (exp_q.size() == 0) check_eq("unexpected_code", 32'(data_prev), 32'hFFFF_FFFF);
          else check_eq("code", 32'(data_prev), 32'(exp_q.pop_front()));
        end
        flag_prev = oKeyboardFlag;
        data_prev = oData;
      end
    end
  end

  initial begin
    #990_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      iPS2Data = bits[i];
      tick(H);
      iPS2Clock = 1'b0;
      if (i == 10) stop_cyc = cyc;
      tick(H);
      iPS2Clock = 1'b1;
    end
    tick(H);
    iPS2Data = 1'b1;
    tick(H);
  endtask

  task automatic send_code(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_frame(b, bad_par, bad_stop, 11);
    if (bad_stop || (bad_par && ParChk)) exp_err++;
    else model_byte(b);
  endtask

  task automatic wait_flag(input logic level, input int budget, input string tag);
    for (int i = 0; i < budget && oKeyboardFlag !== level; i++) tick(1);
    check_eq(tag, 32'(oKeyboardFlag), 32'(level));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && (exp_q.size() != 0 || oKeyboardFlag); i++) tick(1);
    tick(5);
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] code;
    int         r;
    Reset          = 1'b1;
    iPS2Clock      = 1'b1;
    iPS2Data       = 1'b1;
    iKeyboardReset = 1'b0;
    tick(3);
    check_eq("rst_data", 32'(oData), 32'h0);
    check_eq("rst_flag", 32'(oKeyboardFlag), 32'h0);
    check_eq("rst_err", 32'(oFrameError), 32'h0);
    Reset = 1'b0;
    tick(10);

    // 1: single make, latency and hold duration
    send_code(8'h1D, 1'b0, 1'b0);
    wait_flag(1'b1, 100, "t1_rise");
    check_eq("t1_data", 32'(oData), 32'h1D);
    wait_flag(1'b0, FH + 50, "t1_fall");
    tick(1);
    check_eq("t1_latency", rise_cyc - stop_cyc, 3 + FL);
    check_eq("t1_hold", fall_cyc - rise_cyc, FH);
    check_eq("t1_err", err_seen, exp_err);

    // 2: break sequence after a make
    send_code(8'h1C, 1'b0, 1'b0);
    send_code(8'hF0, 1'b0, 1'b0);
    send_code(8'h1D, 1'b0, 1'b0);
    drain("t2_drain");
    check_eq("t2_data", 32'(oData), 32'h1C);

    // 3: extended prefix
    send_code(8'hE0, 1'b0, 1'b0);
    send_code(8'h5A, 1'b0, 1'b0);
    drain("t3_drain");
    check_eq("t3_data", 32'(oData), 32'h5A);

    // 4: wrong parity
    send_code(8'h23, 1'b1, 1'b0);
    drain("t4_drain");
    check_eq("t4_data", 32'(oData), 32'(last_code));
    check_eq("t4_err", err_seen, exp_err);

    // 5: stalled clock after 4 data bits, then a full frame
    send_frame(8'h55, 1'b0, 1'b0, 5);
    exp_err++;
    tick(TO + 50);
    check_eq("t5_timeout_err", err_seen, exp_err);
    send_code(8'h1B, 1'b0, 1'b0);
    drain("t5_drain");
    check_eq("t5_data", 32'(oData), 32'h1B);

    // Start-bit error (fall with data high) and stop-bit error
    tick(H);
    iPS2Clock = 1'b0;
    tick(H);
    iPS2Clock = 1'b1;
    tick(2 * H);
    exp_err++;
    check_eq("start_err", err_seen, exp_err);
    send_code(8'h44, 1'b0, 1'b1);
    tick(5);
    check_eq("stop_err", err_seen, exp_err);

    // iKeyboardReset drops the flag within one cycle; no effect while flag is low
    send_code(8'h5A, 1'b0, 1'b0);
    wait_flag(1'b1, 100, "kbr_rise");
    iKeyboardReset = 1'b1;
    tick(1);
    iKeyboardReset = 1'b0;
    check_eq("kbr_flag", 32'(oKeyboardFlag), 32'h0);
    tick(3);
    iKeyboardReset = 1'b1;
    tick(2);
    iKeyboardReset = 1'b0;
    check_eq("kbr_idle_flag", 32'(oKeyboardFlag), 32'h0);
    check_eq("kbr_idle_data", 32'(oData), 32'h5A);

    // Back-to-back codes: second accept lands while flag is still high
    send_code(8'h11, 1'b0, 1'b0);
    send_code(8'h12, 1'b0, 1'b0);
    drain("b2b_drain");
    check_eq("b2b_data", 32'(oData), 32'h12);

    // 6: reset mid-frame, short glitch, then a clean frame
    send_frame(8'h33, 1'b0, 1'b0, 4);
    Reset = 1'b1;
    #1;
    check_eq("t6_rst_data", 32'(oData), 32'h0);
    check_eq("t6_rst_flag", 32'(oKeyboardFlag), 32'h0);
    tick(3);
    Reset     = 1'b0;
    brk       = 1'b0;
    last_code = 8'h00;
    tick(5);
    iPS2Clock = 1'b0;
    tick(2);
    iPS2Clock = 1'b1;
    tick(10);
    send_code(8'h2D, 1'b0, 1'b0);
    drain("t6_drain");
    tick(TO);
    check_eq("t6_data", 32'(oData), 32'h2D);
    check_eq("t6_err", err_seen, exp_err);

    // Randomized stream
    for (int n = 0; n < 40; n++) begin
      r    = int'($urandom_range(0, 99));
      code = 8'($urandom_range(1, 223));
      if (r < 20) begin
        send_code(8'hF0, 1'b0, 1'b0);
        send_code(code, 1'b0, 1'b0);
      end else if (r < 35) begin
        send_code(8'hE0, 1'b0, 1'b0);
        send_code(code, 1'b0, 1'b0);
      end else if (r < 43) begin
        send_code(code, 1'b1, 1'b0);
      end else if (r < 48) begin
        send_code(code, 1'b0, 1'b1);
      end else begin
        send_code(code, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin
        tick(int'($urandom_range(0, 200)));
        iKeyboardReset = 1'b1;
        tick(1);
        iKeyboardReset = 1'b0;
      end
      tick(int'($urandom_range(0, 40)));
    end
    drain("rand_drain");
    tick(TO + 20);
    check_eq("rand_data", 32'(oData), 32'(last_code));
    check_eq("final_err", err_seen, exp_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
